// File: rtl/game_controller.sv
// Rhythm-game controller: frame-tick sync, edge-detected hit/miss/start, IDLE/COUNTDOWN/PLAY/DONE FSM, score stats.
// Latency: stats visible one cycle after an input edge; frame tick two cycles after frame_clk rise. COMBO_BONUS_EN adds combo-tier bonus points.
module game_controller #(
    parameter logic [7:0]  COUNTDOWN_FRAMES = 8'd180,
    parameter logic [15:0] HIT_POINTS       = 16'd10
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       frame_clk,
    input  logic       start_btn,
    input  logic [7:0] hit,
    input  logic [7:0] miss,
    input  logic [7:0] song_over,
    output logic       blocks_start,
    output logic [1:0] state,
    output logic [15:0] score,
    output logic [8:0] combo,
    output logic [8:0] max_combo,
    output logic [8:0] hit_count,
    output logic [8:0] miss_count,
    output logic [7:0] countdown,
    output logic       game_over
);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CD   = 2'b01;
    localparam logic [1:0] ST_PLAY = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    logic        fclk_s1_q, fclk_s2_q, tick_q;
    logic [7:0]  hit_prev_q, miss_prev_q;
    logic        start_prev_q, mask_q;
    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] score_q, score_d;
    logic [8:0]  combo_q, combo_d, max_q, max_d, hc_q, hc_d, mc_q, mc_d;

    logic [7:0]  hit_e, miss_e;
    logic        start_e;
    logic [3:0]  n_hit, n_miss;
    logic [16:0] pts;
    logic [21:0] score_sum;
    logic [9:0]  combo_sum, hc_sum, mc_sum;
    logic [8:0]  combo_base, combo_nxt, hc_nxt, mc_nxt;
    logic [15:0] score_nxt;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    // The first cycle after reset only re-arms the edge detectors, so a level held through reset is not an event.
    assign hit_e   = hit & ~hit_prev_q & {8{~mask_q}};
    assign miss_e  = miss & ~miss_prev_q & ~hit_e & {8{~mask_q}};
    assign start_e = start_btn & ~start_prev_q & ~mask_q;
    assign n_hit   = popcnt8(hit_e);
    assign n_miss  = popcnt8(miss_e);

`ifdef COMBO_BONUS_EN
    assign pts = {1'b0, HIT_POINTS} + ((combo_q >= 9'd50) ? 17'd10 :
                                       (combo_q >= 9'd20) ? 17'd5 : 17'd0);
`else
    assign pts = {1'b0, HIT_POINTS};
`endif

    assign score_sum  = {6'd0, score_q} + {1'b0, 21'(n_hit) * 21'(pts)};
    assign score_nxt  = (|score_sum[21:16]) ? 16'hFFFF : score_sum[15:0];
    assign combo_base = (n_miss != 4'd0) ? 9'd0 : combo_q;
    assign combo_sum  = {1'b0, combo_base} + {6'd0, n_hit};
    assign combo_nxt  = combo_sum[9] ? 9'h1FF : combo_sum[8:0];
    assign hc_sum     = {1'b0, hc_q} + {6'd0, n_hit};
    assign hc_nxt     = hc_sum[9] ? 9'h1FF : hc_sum[8:0];
    assign mc_sum     = {1'b0, mc_q} + {6'd0, n_miss};
    assign mc_nxt     = mc_sum[9] ? 9'h1FF : mc_sum[8:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        combo_d = combo_q;
        max_d   = max_q;
        hc_d    = hc_q;
        mc_d    = mc_q;
        case (state_q)
            ST_IDLE: begin
                if (start_e) begin
                    state_d = ST_CD;
                    cnt_d   = COUNTDOWN_FRAMES;
                end
            end
            ST_CD: begin
                if (tick_q) begin
                    if (cnt_q <= 8'd1) begin
                        state_d = ST_PLAY;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                score_d = score_nxt;
                combo_d = combo_nxt;
                hc_d    = hc_nxt;
                mc_d    = mc_nxt;
                if (combo_nxt > max_q) max_d = combo_nxt;
                if (&song_over) state_d = ST_DONE;
            end
            default: begin
                if (start_e) begin
                    state_d = ST_CD;
                    cnt_d   = COUNTDOWN_FRAMES;
                    score_d = 16'd0;
                    combo_d = 9'd0;
                    max_d   = 9'd0;
                    hc_d    = 9'd0;
                    mc_d    = 9'd0;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            fclk_s1_q    <= 1'b0;
            fclk_s2_q    <= 1'b0;
            tick_q       <= 1'b0;
            hit_prev_q   <= 8'd0;
            miss_prev_q  <= 8'd0;
            start_prev_q <= 1'b0;
            mask_q       <= 1'b1;
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            score_q      <= 16'd0;
            combo_q      <= 9'd0;
            max_q        <= 9'd0;
            hc_q         <= 9'd0;
            mc_q         <= 9'd0;
        end else begin
            fclk_s1_q    <= frame_clk;
            fclk_s2_q    <= fclk_s1_q;
            tick_q       <= fclk_s1_q & ~fclk_s2_q;
            hit_prev_q   <= hit;
            miss_prev_q  <= miss;
            start_prev_q <= start_btn;
            mask_q       <= 1'b0;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score_q      <= score_d;
            combo_q      <= combo_d;
            max_q        <= max_d;
            hc_q         <= hc_d;
            mc_q         <= mc_d;
        end
    end

    assign state        = state_q;
    assign blocks_start = (state_q != ST_PLAY);
    assign game_over    = (state_q == ST_DONE);
    assign countdown    = cnt_q;
    assign score        = score_q;
    assign combo        = combo_q;
    assign max_combo    = max_q;
    assign hit_count    = hc_q;
    assign miss_count   = mc_q;
endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter: COUNTDOWN_FRAMES, 8'd180, frame ticks spent in COUNTDOWN before play starts.
REQ-002 Parameter: HIT_POINTS, 16'd10, base score added per counted hit.
REQ-003 Port: Clk  input  1  system clock; sole clock of the block.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: frame_clk  input  1  vertical-sync frame clock, asynchronous to game state, sampled on Clk.
REQ-006 Port: start_btn  input  1  level start request (key or button).
REQ-007 Port: hit  input  8  per-lane hit level from the eight note-block instances.
REQ-008 Port: miss  input  8  per-lane miss level from the note-block instances.
REQ-009 Port: song_over  input  8  per-lane song-finished level.
REQ-010 Port: blocks_start  output  1  held high to freeze note blocks at their initial positions.
REQ-011 Port: state  output  2  00 IDLE, 01 COUNTDOWN, 10 PLAY, 11 DONE.
REQ-012 Port: score  output  16  accumulated score.
REQ-013 Port: combo  output  9  current consecutive-hit count.
REQ-014 Port: max_combo  output  9  largest combo this game.
REQ-015 Port: hit_count, miss_count  output  9 each  counted hit/miss events this game.
REQ-016 Port: countdown  output  8  frame ticks remaining in COUNTDOWN; 0 otherwise.
REQ-017 Port: game_over  output  1  high while in DONE.

Function
REQ-018 frame tick SHALL be a one-Clk pulse, registered one cycle after frame_clk is sampled high following a low sample.
REQ-019 hit, miss, start_btn SHALL each be edge-detected per bit against their previous-cycle sample; only 0->1 transitions count as events.
REQ-020 On a lane with hit and miss edges in the same cycle, only the hit SHALL count.
REQ-021 IDLE: blocks_start=1; start_btn edge -> COUNTDOWN with countdown=COUNTDOWN_FRAMES.
REQ-022 COUNTDOWN: blocks_start=1; each frame tick decrements countdown; tick while countdown==1 -> PLAY, countdown=0.
REQ-023 PLAY: blocks_start=0; when all eight song_over bits are high -> DONE on the next cycle.
REQ-024 DONE: blocks_start=1, game_over=1, all statistics frozen; start_btn edge -> COUNTDOWN, clearing score, combo, max_combo, hit_count, miss_count in that same cycle.
REQ-025 start_btn edges in COUNTDOWN or PLAY SHALL be ignored.
REQ-026 Hit/miss events SHALL update statistics only in PLAY, with the update visible one cycle after the input edge.
REQ-027 Per cycle, with H = count of hit events and M = count of miss events: hit_count += H, miss_count += M, combo_next = (M>0 ? 0 : combo) + H.
REQ-028 score += H * per-hit points; score, combo, hit_count, miss_count SHALL saturate at all-ones, never wrap.
REQ-029 max_combo SHALL update to combo_next whenever combo_next exceeds it.

Reset
REQ-030 reset SHALL force state=IDLE, blocks_start=1, score=0, combo=0, max_combo=0, hit_count=0, miss_count=0, countdown=0, game_over=0, and clear all edge-detect and frame-sync registers, at any state including mid-PLAY.
REQ-031 An input edge present in the reset cycle SHALL not be counted after reset releases.

Configuration
REQ-032 Macro COMBO_BONUS_EN: when defined, per-hit points = HIT_POINTS + (combo>=50 ? 10 : combo>=20 ? 5 : 0), evaluated on combo before the cycle's update; when undefined, per-hit points = HIT_POINTS.

Verification
REQ-033 Reset, start_btn pulse, 180 frame ticks -> countdown steps 180..1, state=PLAY after the 180th tick, blocks_start falls the same cycle.
REQ-034 In PLAY, hit=8'b0000_0101 rising in one cycle -> next cycle score=20, combo=2, hit_count=2.
REQ-035 In PLAY with combo=3, hit[1] and miss[2] rising together -> combo=1, max_combo=3, miss_count=1, score+=10.
REQ-036 hit[0] held high for 100 cycles -> exactly one hit counted; hit and miss on lane 0 rising together -> hit counted, miss_count unchanged.
REQ-037 song_over=8'hFF in PLAY -> DONE, game_over=1, further hit edges ignored; start_btn edge -> COUNTDOWN with all statistics 0.
REQ-038 With COMBO_BONUS_EN, combo=20 then one hit -> score+=15; combo=50 then one hit -> score+=20; reset asserted mid-PLAY -> all outputs at reset values next cycle.
